product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulation stage directly downstream of the 32x32 signed array multiplier. It consumes a programmed number of signed 64-bit products over a valid/ready handshake and sums them into a wide signed accumulator with optional saturation. It then presents the final sum, plus a sticky overflow flag, on an output valid/ready handshake. Together with the multiplier it forms the dot-product/MAC datapath.

## Interface
- PROD_W, 64, product width; matches the multiplier output.
- ACC_W, 72, accumulator/result width; must satisfy ACC_W >= PROD_W.
- CNT_W, 16, width of the term count.
- SAT, 1, 1 = saturate on overflow; 0 = two's-complement wrap.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a new accumulation; honoured only in IDLE.
- len  in  CNT_W  number of products to sum; sampled when start is honoured.
- prod_valid  in  1  product present.
- prod  in  PROD_W  signed product from the multiplier.
- prod_ready  out  1  stage accepts a product this cycle.
- res_valid  out  1  result available.
- res  out  ACC_W  signed accumulated sum.
- res_ovf  out  1  at least one overflow occurred during this accumulation (sticky).
- res_ready  in  1  consumer takes the result.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE → ACCUM on start with len != 0: acc <= 0, ovf <= 0, remaining <= len.
- IDLE → DONE on start with len == 0: acc <= 0, ovf <= 0; the result is 0 with no overflow.
- ACCUM behaviour:
  - prod_ready = 1.
  - On each transfer (prod_valid & prod_ready), acc <= acc + sign_extend(prod) and remaining decrements.
  - When the transfer with remaining == 1 occurs, the next state is DONE.
- DONE behaviour:
  - res_valid = 1; res and res_ovf hold stable.
  - On res_valid & res_ready, the next state is IDLE.
- Overflow detection: operands have the same sign and the sum sign differs.
  - ovf becomes 1 and stays set until the next start.
  - SAT=1: acc is clamped to +2^(ACC_W-1)-1 or -2^(ACC_W-1), according to the operand sign.
  - SAT=0: acc wraps.
- Once saturated, later terms add normally from the clamped value and may move it back into range. Saturation is not absorbing.
- start outside IDLE is ignored; len is not resampled.
- prod_valid outside ACCUM is ignored and no product is consumed.

## Timing
- Reset values: state IDLE, prod_ready 0, res_valid 0, res 0, res_ovf 0, busy 0, acc 0, remaining 0.
- Reset asserted mid-accumulation aborts immediately and asynchronously; no partial result is ever presented.
- prod_ready and res_valid are registered state decodes; neither depends combinationally on prod_valid or res_ready.
- Throughput: one product per cycle in ACCUM.
- Latency: res_valid rises on the cycle after the last product transfer; a back-to-back stream of N products gives res_valid N cycles after the first product cycle.
- Start to ACCUM: prod_ready is high on the cycle after start.
- len == 0: res_valid is high on the cycle after start.
- res_ready held high in DONE: one cycle in DONE, then IDLE. A new start is honoured in the IDLE cycle that follows, not in the DONE cycle.
- Backpressure: res, res_ovf and res_valid hold unchanged while res_ready is low.
- Stalls: gaps in prod_valid are tolerated without limit. remaining counts only transfers.

## Structure
- Shared package mult_pkg holds:
  - PROD_W, ACC_W and CNT_W defaults;
  - the acc_state_t enum {IDLE, ACCUM, DONE};
  - the ACC_MAX and ACC_MIN saturation constants.
- One sub-module, sat_adder: combinational ACC_W-bit signed add with overflow output and SAT-controlled clamp.
- The FSM, counter and registers live in product_accumulator.

## Test plan
- Basic sum: start, len=3, then products 50, -50, 83810205 back-to-back → res=83810205, res_ovf=0; res_valid exactly 3 cycles after the first product cycle.
- Zero length: start, len=0 → res_valid on the next cycle, res=0, res_ovf=0, prod_ready stays 0 throughout.
- Saturation, ACC_W=64: start, len=2, then prods 0x7FFF_FFFF_FFFF_FFFF and 1.
  - SAT=1 → res=0x7FFF_FFFF_FFFF_FFFF, res_ovf=1.
  - SAT=0 → res=0x8000_0000_0000_0000, res_ovf=1.
- Handshake stress: len=4 with random prod_valid gaps and res_ready held low for 5 cycles.
  - Exactly 4 products are consumed.
  - res stays stable while stalled.
  - A start pulsed during ACCUM is ignored.
- Reset mid-operation: rst_n low after 2 of 5 products → all outputs zero immediately; a new start with len=1 and prod -4294967296 → res=-4294967296.
- Wide accumulation, default ACC_W=72: start, len=256, every product = 2^62 (0x4000_0000_0000_0000) → res=2^70, res_ovf=0; the sum would overflow 64 bits but fits within 72.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / product accumulator datapath.
package mult_pkg;
    localparam int PROD_W = 64;
    localparam int ACC_W  = 72;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational signed W-bit adder with overflow flag and optional clamp.
module sat_adder #(
    parameter int W   = 72,
    parameter bit SAT = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        sum = raw;
        // Both operands share a sign on overflow, so a's sign picks the rail.
        if (SAT && ovf)
            sum = a[W-1] ? MIN : MAX;
    end
endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed products into a wide accumulator and
// presents the total with a sticky overflow flag over valid/ready.
module product_accumulator #(
    parameter int PROD_W = mult_pkg::PROD_W,
    parameter int ACC_W  = mult_pkg::ACC_W,
    parameter int CNT_W  = mult_pkg::CNT_W,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res,
    output logic              res_ovf,
    input  logic              res_ready,
    output logic              busy
);
    import mult_pkg::*;

    acc_state_t       state, state_nx;
    logic [ACC_W-1:0] acc, prod_ext, acc_sum;
    logic             ovf, add_ovf;
    logic [CNT_W-1:0] remaining;

    assign prod_ext = ACC_W'($signed(prod));

    sat_adder #(.W(ACC_W), .SAT(SAT)) u_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (acc_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (prod_valid && remaining == CNT_W'(1)) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc       <= '0;
                    ovf       <= 1'b0;
                    remaining <= len;
                end
                ACCUM: if (prod_valid) begin
                    acc       <= acc_sum;
                    ovf       <= ovf | add_ovf;
                    remaining <= remaining - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes, never combinational on inputs.
    assign prod_ready = (state == ACCUM);
    assign res_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign res        = acc;
    assign res_ovf    = ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: three instances (72-bit saturating, 64-bit saturating,
// 64-bit wrapping) share stimulus; results are scored against a queue.
module tb_product_accumulator;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, prod_valid = 1'b0, res_ready = 1'b0;
    logic [15:0] len = '0;
    logic [63:0] prod = '0;

    logic        pr72, rv72, o72, b72;
    logic [71:0] r72;
    logic        prs, rvs, os, bs;
    logic [63:0] rs;
    logic        prw, rvw, ow, bw;
    logic [63:0] rw;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16), .SAT(1'b1)) u72 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(pr72), .res_valid(rv72), .res(r72), .res_ovf(o72),
        .res_ready(res_ready), .busy(b72));
    product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16), .SAT(1'b1)) u64s (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(prs), .res_valid(rvs), .res(rs), .res_ovf(os),
        .res_ready(res_ready), .busy(bs));
    product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16), .SAT(1'b0)) u64w (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(prw), .res_valid(rvw), .res(rw), .res_ovf(ow),
        .res_ready(res_ready), .busy(bw));

    typedef struct packed {
        logic [71:0] r72;
        logic        o72;
        logic [63:0] r64s;
        logic        o64s;
        logic [63:0] r64w;
        logic        o64w;
    } exp_t;

    typedef struct packed {
        int              n;
        logic [3:0][63:0] p;
        exp_t            e;
    } vec_t;

    exp_t        sb[$];
    logic [63:0] pq[$];
    int          tests = 0, fails = 0;
    int unsigned xfer = 0;

    always @(posedge clk) if (prod_valid && pr72) xfer <= xfer + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mke(input logic [71:0] a, input logic ao, input logic [63:0] s,
                                 input logic so, input logic [63:0] w, input logic wo);
        exp_t e;
        e.r72 = a; e.o72 = ao; e.r64s = s; e.o64s = so; e.r64w = w; e.o64w = wo;
        return e;
    endfunction

    function automatic vec_t mkv(input int n, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [63:0] d, input exp_t e);
        vec_t v;
        v.n = n; v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d; v.e = e;
        return v;
    endfunction

    task automatic run(input string nm, input int n, input exp_t e, input bit gaps,
                       input int stall, input bit start_in_done);
        int          idx, lat, guard;
        int unsigned snap;
        exp_t        x;
        idx = 0; lat = 0; guard = 0;
        sb.push_back(e);
        snap  = xfer;
        start = 1'b1; len = 16'(n);
        step();
        start = 1'b0; len = 16'hFFFF;
        chk({nm, ".busy"}, 72'(b72), 72'(1));
        chk({nm, ".prdy"}, 72'(pr72), 72'(n != 0));
        while (!rv72 && guard < 2000) begin
            start = (gaps && lat == 2);
            if (start) len = 16'd9;
            prod_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
            prod       = prod_valid ? pq[idx] : 64'h0BAD_0BAD_0BAD_0BAD;
            if (prod_valid && pr72) idx++;
            step();
            lat++; guard++;
        end
        start = 1'b0; prod_valid = 1'b0;
        if (!rv72) chk({nm, ".timeout"}, 72'(rv72), 72'(1));
        if (!gaps) chk({nm, ".lat"}, 72'(lat), 72'(n));
        x = sb.pop_front();
        chk({nm, ".r72"}, r72, x.r72);
        chk({nm, ".o72"}, 72'(o72), 72'(x.o72));
        chk({nm, ".r64s"}, 72'(rs), 72'(x.r64s));
        chk({nm, ".o64s"}, 72'(os), 72'(x.o64s));
        chk({nm, ".r64w"}, 72'(rw), 72'(x.r64w));
        chk({nm, ".o64w"}, 72'(ow), 72'(x.o64w));
        chk({nm, ".consumed"}, 72'(xfer - snap), 72'(n));
        for (int k = 0; k < stall; k++) begin
            prod_valid = 1'b1; prod = 64'd1;
            step();
            chk({nm, ".stall_rv"}, 72'(rv72), 72'(1));
            chk({nm, ".stall_res"}, r72, x.r72);
            chk({nm, ".stall_ovf"}, 72'(o72), 72'(x.o72));
        end
        prod_valid = 1'b0;
        if (stall > 0) chk({nm, ".consumed_stall"}, 72'(xfer - snap), 72'(n));
        res_ready = 1'b1; start = start_in_done; len = 16'd1;
        step();
        res_ready = 1'b0; start = 1'b0;
        chk({nm, ".idle_rv"}, 72'(rv72), 72'(0));
        chk({nm, ".idle_busy"}, 72'(b72), 72'(0));
        if (start_in_done) begin
            step();
            chk({nm, ".done_start_ignored"}, 72'(b72), 72'(0));
        end
    endtask

    initial begin
        vec_t        v[7];
        int unsigned snap;
        v[0] = mkv(3, 64'd50, 64'hFFFF_FFFF_FFFF_FFCE, 64'd83810205, 64'd0,
                   mke(72'd83810205, 0, 64'd83810205, 0, 64'd83810205, 0));
        v[1] = mkv(0, 64'd0, 64'd0, 64'd0, 64'd0, mke(72'd0, 0, 64'd0, 0, 64'd0, 0));
        v[2] = mkv(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                   mke(72'h00_8000_0000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1,
                       64'h8000_0000_0000_0000, 1));
        v[3] = mkv(4, 64'd1, 64'd2, 64'd3, 64'd4, mke(72'd10, 0, 64'd10, 0, 64'd10, 0));
        v[4] = mkv(2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                   mke(72'hFF_7FFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 1,
                       64'h7FFF_FFFF_FFFF_FFFF, 1));
        v[5] = mkv(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
                   mke(72'h00_7FFF_FFFF_FFFF_FFFE, 0, 64'h7FFF_FFFF_FFFF_FFFD, 1,
                       64'h7FFF_FFFF_FFFF_FFFE, 1));
        v[6] = mkv(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   mke(72'hFF_FFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0,
                       64'hFFFF_FFFF_FFFF_FFFC, 0));

        repeat (2) step();
        chk("rst.prdy", 72'(pr72), 72'(0));
        chk("rst.rv", 72'(rv72), 72'(0));
        chk("rst.res", r72, 72'd0);
        chk("rst.ovf", 72'(o72), 72'(0));
        chk("rst.busy", 72'(b72), 72'(0));
        chk("rst.res64w", 72'(rw), 72'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            pq.delete();
            for (int j = 0; j < v[i].n; j++) pq.push_back(v[i].p[j]);
            run($sformatf("vec%0d", i), v[i].n, v[i].e, 1'b0, 0, 1'b0);
        end

        pq.delete();
        pq.push_back(64'd5); pq.push_back(64'd6); pq.push_back(64'd7); pq.push_back(64'd8);
        run("stress", 4, mke(72'd26, 0, 64'd26, 0, 64'd26, 0), 1'b1, 5, 1'b1);

        // Abort mid-stream: two of five products taken, then async reset.
        snap  = xfer;
        start = 1'b1; len = 16'd5;
        step();
        start = 1'b0; prod_valid = 1'b1; prod = 64'd11;
        step();
        prod = 64'd22;
        step();
        prod = 64'd33;
        #2 rst_n = 1'b0;
        #1;
        chk("abort.res", r72, 72'd0);
        chk("abort.rv", 72'(rv72), 72'(0));
        chk("abort.prdy", 72'(pr72), 72'(0));
        chk("abort.ovf", 72'(o72), 72'(0));
        chk("abort.busy", 72'(b72), 72'(0));
        chk("abort.consumed", 72'(xfer - snap), 72'(2));
        prod_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("abort.idle_rv", 72'(rv72), 72'(0));
        pq.delete();
        pq.push_back(64'hFFFF_FFFF_0000_0000);
        run("after_rst", 1, mke(72'hFF_FFFF_FFFF_0000_0000, 0, 64'hFFFF_FFFF_0000_0000, 0,
                                64'hFFFF_FFFF_0000_0000, 0), 1'b0, 0, 1'b0);

        pq.delete();
        for (int j = 0; j < 256; j++) pq.push_back(64'h4000_0000_0000_0000);
        run("wide", 256, mke(72'h40_0000_0000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1,
                             64'd0, 1), 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
